// File: rtl/monsters_pkg.sv
// Shared types, default sprite geometry and the pixel-art generators used by
// the silhouette ROM.
package monsters_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_EXPLODING = 2'd1,
    ST_DEAD      = 2'd2
  } monster_state_t;

  localparam int unsigned DEF_SPRITE_W = 32;
  localparam int unsigned DEF_SPRITE_H = 32;
  localparam int unsigned OFFSET_W     = 11;
  localparam int unsigned TICK_W       = 8;

  function automatic int unsigned frame_idx_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic logic in_span(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Idle monster: body with two eye holes; legs and antennae swap on odd frames.
  function automatic logic alive_bit(input int f, input int r, input int c);
    logic odd, body, eye, legs, ant;
    odd  = (f % 2) != 0;
    body = in_span(r, 8, 23) && in_span(c, 6, 25);
    eye  = in_span(r, 12, 14) && (in_span(c, 11, 13) || in_span(c, 18, 20));
    legs = in_span(r, 24, 27) &&
           (odd ? (in_span(c, 4, 7) || in_span(c, 24, 27))
                : (in_span(c, 8, 11) || in_span(c, 20, 23)));
    ant  = in_span(r, 2, 7) && (odd ? (c == 12 || c == 19) : (c == 10 || c == 21));
    return (body && !eye) || legs || ant;
  endfunction

  // Explosion: expanding diamond ring of width 5; from frame 2 on it breaks into a checker.
  function automatic logic expl_bit(input int f, input int r, input int c,
                                    input int cx, input int cy);
    int   d, lo;
    logic on;
    d  = iabs(r - cy) + iabs(c - cx);
    lo = 5 * f;
    on = in_span(d, lo, lo + 4);
    if (f >= 2) on = on && (((r + c) % 2) == 0);
    return on;
  endfunction

endpackage

// File: rtl/animated_silhouette_if.sv
// Pixel-pipeline signal bundle between the video timing/collision logic and
// the animated sprite.
interface animated_silhouette_if;
  import monsters_pkg::*;

  logic                startOfFrame;
  logic [OFFSET_W-1:0] offsetX;
  logic [OFFSET_W-1:0] offsetY;
  logic                InsideRectangle;
  logic                monsterIsHit;
  logic                revive;
  logic                drawingRequest;
  logic                isExploding;
  logic                explosionDone;

  modport master (
    output startOfFrame, offsetX, offsetY, InsideRectangle, monsterIsHit, revive,
    input  drawingRequest, isExploding, explosionDone
  );

  modport slave (
    input  startOfFrame, offsetX, offsetY, InsideRectangle, monsterIsHit, revive,
    output drawingRequest, isExploding, explosionDone
  );

endinterface

// File: rtl/silhouette_rom.sv
// Combinational bitmap lookup: (mode, frame, row, col) -> pixel bit, row-major
// with (0,0) at the sprite's top-left corner.
module silhouette_rom
  import monsters_pkg::*;
#(
  parameter int unsigned SPRITE_W = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H = DEF_SPRITE_H,
  parameter int unsigned FRAME_W  = 1
) (
  input  monster_state_t      mode_i,
  input  logic [FRAME_W-1:0]  frame_i,
  input  logic [OFFSET_W-1:0] row_i,
  input  logic [OFFSET_W-1:0] col_i,
  output logic                bit_o
);

  localparam int CX = int'(SPRITE_W / 2);
  localparam int CY = int'(SPRITE_H / 2);

  always_comb begin
    bit_o = 1'b0;
    unique case (mode_i)
      ST_ALIVE:     bit_o = alive_bit(int'(frame_i), int'(row_i), int'(col_i));
      ST_EXPLODING: bit_o = expl_bit(int'(frame_i), int'(row_i), int'(col_i), CX, CY);
      default:      bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/animated_silhouette.sv
// Animated monster sprite: ALIVE/EXPLODING/DEAD sequencing, frame/tick counters
// and registered pixel, explosion and done outputs.
module animated_silhouette
  import monsters_pkg::*;
#(
  parameter int unsigned SPRITE_W     = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H     = DEF_SPRITE_H,
  parameter int unsigned ALIVE_FRAMES = 2,
  parameter int unsigned EXPL_FRAMES  = 3,
  parameter int unsigned FRAME_TICKS  = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  animated_silhouette_if.slave   bus
);

  localparam int unsigned FW = frame_idx_w(ALIVE_FRAMES, EXPL_FRAMES);

  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FW-1:0]       ALIVE_LAST = FW'(ALIVE_FRAMES - 1);
  localparam logic [FW-1:0]       EXPL_LAST  = FW'(EXPL_FRAMES - 1);
  localparam logic [OFFSET_W-1:0] W_LIM      = OFFSET_W'(SPRITE_W);
  localparam logic [OFFSET_W-1:0] H_LIM      = OFFSET_W'(SPRITE_H);

  monster_state_t    state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic              draw_q,  draw_d;
  logic              expl_q,  expl_d;
  logic              done_q,  done_d;
  logic              rom_bit;

  silhouette_rom #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .FRAME_W  (FW)
  ) u_rom (
    .mode_i  (state_q),
    .frame_i (frame_q),
    .row_i   (bus.offsetY),
    .col_i   (bus.offsetX),
    .bit_o   (rom_bit)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_ALIVE;
      frame_q <= '0;
      tick_q  <= '0;
      draw_q  <= 1'b0;
      expl_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      draw_q  <= draw_d;
      expl_q  <= expl_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tick_d  = tick_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_ALIVE: begin
        // A hit wins over a coincident frame tick.
        if (bus.monsterIsHit) begin
          state_d = ST_EXPLODING;
          frame_d = '0;
          tick_d  = '0;
        end else if (bus.startOfFrame) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            frame_d = (frame_q == ALIVE_LAST) ? '0 : frame_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_EXPLODING: begin
        if (bus.startOfFrame) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (frame_q == EXPL_LAST) begin
              state_d = ST_DEAD;
              frame_d = '0;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_DEAD: begin
        if (bus.revive) begin
          state_d = ST_ALIVE;
          frame_d = '0;
          tick_d  = '0;
        end
      end

      default: begin
        state_d = ST_ALIVE;
        frame_d = '0;
        tick_d  = '0;
      end
    endcase

    // Decoded from the next state so the flag lines up with state_q.
    expl_d = (state_d == ST_EXPLODING);
    draw_d = bus.InsideRectangle && (bus.offsetX < W_LIM) && (bus.offsetY < H_LIM) &&
             (state_q != ST_DEAD) && rom_bit;
  end

  assign bus.drawingRequest = draw_q;
  assign bus.isExploding    = expl_q;
  assign bus.explosionDone  = done_q;

endmodule

// File: tb/tb_animated_silhouette.sv
// Directed bench for animated_silhouette with FRAME_TICKS=2: reset, idle
// animation, explosion, death, revive and reset abort.
module tb_animated_silhouette;

  logic clk = 1'b0;
  logic resetN;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  animated_silhouette_if sil_if ();

  animated_silhouette #(
    .SPRITE_W     (32),
    .SPRITE_H     (32),
    .ALIVE_FRAMES (2),
    .EXPL_FRAMES  (3),
    .FRAME_TICKS  (2)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (sil_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic put(input int x, input int y);
    sil_if.offsetX = 11'(x);
    sil_if.offsetY = 11'(y);
  endtask

  task automatic pulse_sof();
    sil_if.startOfFrame = 1'b1;
    tick();
    sil_if.startOfFrame = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic exp);
    put(x, y);
    tick();
    check(tag, sil_if.drawingRequest, exp);
  endtask

  // Probe pixels: (16,12) body / explosion frame 0, (9,25) leg of idle frame 0,
  // (5,25) leg of idle frame 1, (16,7) explosion frame 1, (16,6) explosion frame 2.
  initial begin
    sil_if.startOfFrame    = 1'b0;
    sil_if.monsterIsHit    = 1'b0;
    sil_if.revive          = 1'b0;
    sil_if.InsideRectangle = 1'b1;
    put(16, 12);
    resetN = 1'b1;
    #1 resetN = 1'b0;

    tick();
    check("rst_draw", sil_if.drawingRequest, 1'b0);
    check("rst_expl", sil_if.isExploding, 1'b0);
    check("rst_done", sil_if.explosionDone, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    check("post_rst_draw", sil_if.drawingRequest, 1'b1);

    probe("a_f0_leg0", 9, 25, 1'b1);
    probe("a_f0_leg1", 5, 25, 1'b0);
    put(9, 25);
    pulse_sof();
    check("sof1_leg0", sil_if.drawingRequest, 1'b1);
    pulse_sof();
    check("sof2_latency", sil_if.drawingRequest, 1'b1);
    tick();
    check("a_f1_leg0", sil_if.drawingRequest, 1'b0);
    probe("a_f1_leg1", 5, 25, 1'b1);
    pulse_sof();
    pulse_sof();
    probe("a_wrap_leg0", 9, 25, 1'b1);
    probe("a_wrap_leg1", 5, 25, 1'b0);

    put(16, 12);
    sil_if.monsterIsHit = 1'b1;
    sil_if.startOfFrame = 1'b1;
    tick();
    sil_if.monsterIsHit = 1'b0;
    sil_if.startOfFrame = 1'b0;
    check("hit_expl", sil_if.isExploding, 1'b1);
    check("hit_lat_draw", sil_if.drawingRequest, 1'b1);
    probe("e_f0_r1", 16, 7, 1'b0);
    probe("e_f0_body", 16, 12, 1'b1);
    pulse_sof();
    probe("e_hit_sof_override", 16, 7, 1'b0);
    pulse_sof();
    probe("e_f1_r1", 16, 7, 1'b1);
    sil_if.monsterIsHit = 1'b1;
    tick();
    sil_if.monsterIsHit = 1'b0;
    probe("e_hit_ignored", 16, 7, 1'b1);
    check("e_expl_flag", sil_if.isExploding, 1'b1);
    pulse_sof();
    pulse_sof();
    probe("e_f2_r2", 16, 6, 1'b1);
    probe("e_f2_r1", 16, 7, 1'b0);
    sil_if.revive = 1'b1;
    tick();
    sil_if.revive = 1'b0;
    probe("e_revive_ignored", 16, 6, 1'b1);
    check("e_rev_expl_flag", sil_if.isExploding, 1'b1);
    probe("e_oob_x", 32, 12, 1'b0);
    probe("e_oob_y", 16, 40, 1'b0);
    pulse_sof();
    check("e_p5_expl", sil_if.isExploding, 1'b1);
    check("e_p5_done", sil_if.explosionDone, 1'b0);
    put(16, 6);
    pulse_sof();
    check("p6_draw_lat", sil_if.drawingRequest, 1'b1);
    check("done_pulse", sil_if.explosionDone, 1'b1);
    check("dead_expl", sil_if.isExploding, 1'b0);
    tick();
    check("done_one_cycle", sil_if.explosionDone, 1'b0);
    check("dead_draw", sil_if.drawingRequest, 1'b0);

    probe("d_body", 16, 12, 1'b0);
    probe("d_oob_x", 32, 12, 1'b0);
    probe("d_oob_y", 16, 40, 1'b0);
    sil_if.monsterIsHit = 1'b1;
    tick();
    sil_if.monsterIsHit = 1'b0;
    check("d_hit_ignored", sil_if.isExploding, 1'b0);
    probe("d_still_dead", 16, 12, 1'b0);

    put(9, 25);
    sil_if.revive = 1'b1;
    tick();
    sil_if.revive = 1'b0;
    check("rev_lat_draw", sil_if.drawingRequest, 1'b0);
    check("rev_expl", sil_if.isExploding, 1'b0);
    tick();
    check("rev_alive_leg0", sil_if.drawingRequest, 1'b1);
    probe("a_oob_x", 32, 12, 1'b0);
    probe("a_oob_y", 16, 40, 1'b0);
    sil_if.InsideRectangle = 1'b0;
    probe("a_outside_rect", 16, 12, 1'b0);
    sil_if.InsideRectangle = 1'b1;

    sil_if.monsterIsHit = 1'b1;
    tick();
    sil_if.monsterIsHit = 1'b0;
    check("hit2_expl", sil_if.isExploding, 1'b1);
    probe("e2_f0_r1", 16, 7, 1'b0);
    pulse_sof();
    pulse_sof();
    probe("e2_f1_r1", 16, 7, 1'b1);
    #2 resetN = 1'b0;
    #1;
    check("async_rst_draw", sil_if.drawingRequest, 1'b0);
    check("async_rst_expl", sil_if.isExploding, 1'b0);
    check("async_rst_done", sil_if.explosionDone, 1'b0);
    tick();
    check("abort_done0", sil_if.explosionDone, 1'b0);
    resetN = 1'b1;
    probe("abort_alive_leg0", 9, 25, 1'b1);
    check("abort_done1", sil_if.explosionDone, 1'b0);
    pulse_sof();
    pulse_sof();
    probe("abort_f1_leg1", 5, 25, 1'b1);
    check("abort_done2", sil_if.explosionDone, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
